led_display_sequencer: RTL and testbench

- Owns the 8-bit data bus feeding the board LED driver.
- Shares the LEDs between two requesters, ports 0 and 1 (e.g. host command path and camera status logic), with 2-way round-robin arbitration and a valid/ready handshake.
- Each granted word is displayed for a fixed hold time.
- While no request is being displayed, the block runs a one-hot "chaser" idle pattern.

---
 rtl/nimslo_led_pkg.sv | 8 +
 rtl/led_rr_arbiter.sv | 14 +
 rtl/led_display_sequencer.sv | 113 +++++++++++
 tb/tb_led_display_sequencer.sv | 110 +++++++++++
 4 files changed

// File: rtl/nimslo_led_pkg.sv
// nimslo_led_pkg: shared state encoding, widths and constants for the LED display sequencer.
package nimslo_led_pkg;
   typedef enum logic {ST_IDLE, ST_HOLD} state_e;
   localparam int LED_W = 8;
   localparam int REQ_0 = 0;
   localparam int REQ_1 = 1;
   localparam logic [LED_W-1:0] CHASE_RESET = 8'h01;
endpackage

// File: rtl/led_rr_arbiter.sv
// led_rr_arbiter: 2-way round-robin arbiter; a lone valid port wins, on contention the port not granted last wins.
module led_rr_arbiter
   import nimslo_led_pkg::*;
(
   input  logic [1:0] valid,
   input  logic       last_grant,
   input  logic       enable,
   output logic [1:0] gnt
);
   always_comb begin
      gnt[REQ_0] = enable && valid[REQ_0] && (!valid[REQ_1] || last_grant);
      gnt[REQ_1] = enable && valid[REQ_1] && (!valid[REQ_0] || !last_grant);
   end
endmodule

// File: rtl/led_display_sequencer.sv
// led_display_sequencer: shares the LED bus between two requesters, holds each granted word, runs a chaser when idle.
// Define LED_BLINK_EN to blink the held word with period set by BLINK_CYCLES.
module led_display_sequencer
   import nimslo_led_pkg::*;
#(
   parameter int HOLD_CYCLES = 50_000_000,
   parameter int STEP_CYCLES = 5_000_000,
   parameter int CNT_W = 26
`ifdef LED_BLINK_EN
   ,
   parameter int BLINK_CYCLES = 12_500_000
`endif
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   input  logic [LED_W-1:0] req0_data,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [LED_W-1:0] req1_data,
   output logic             req1_ready,
   output logic [LED_W-1:0] led_data,
   output logic [1:0]       grant,
   output logic             busy
);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
   state_e state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [LED_W-1:0] chase, chase_nx, word, word_nx, win_data;
   logic [1:0] gnt, grant_nx;
   logic last, last_nx, busy_nx;
   led_rr_arbiter u_arb (
      .valid      ({req1_valid, req0_valid}),
      .last_grant (last),
      .enable     (rst && state == ST_IDLE),
      .gnt        (gnt)
   );
   assign req0_ready = gnt[REQ_0];
   assign req1_ready = gnt[REQ_1];
   assign win_data = gnt[REQ_1] ? req1_data : req0_data;
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt + 1'b1;
      chase_nx = chase;
      word_nx  = word;
      grant_nx = grant;
      last_nx  = last;
      busy_nx  = busy;
      if (state == ST_IDLE) begin
         if (|gnt) begin
            state_nx = ST_HOLD;
            cnt_nx   = '0;
            word_nx  = win_data;
            grant_nx = gnt;
            last_nx  = gnt[REQ_1];
            busy_nx  = 1'b1;
         end else begin
            word_nx = chase;
            if (cnt == STEP_LAST) begin
               cnt_nx   = '0;
               chase_nx = {chase[LED_W-2:0], chase[LED_W-1]};
            end
         end
      end else if (cnt == HOLD_LAST) begin
         state_nx = ST_IDLE;
         cnt_nx   = '0;
         grant_nx = '0;
         busy_nx  = 1'b0;
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
         chase <= CHASE_RESET;
         word  <= '0;
         grant <= '0;
         last  <= 1'b1;
         busy  <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         chase <= chase_nx;
         word  <= word_nx;
         grant <= grant_nx;
         last  <= last_nx;
         busy  <= busy_nx;
      end
   end
`ifdef LED_BLINK_EN
   localparam int BLK_W = $clog2(BLINK_CYCLES + 1);
   localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_CYCLES - 1);
   logic [BLK_W-1:0] bcnt;
   logic phase;
   // Blink only while staying in HOLD; any transfer or exit restarts with the word visible.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bcnt  <= '0;
         phase <= 1'b0;
      end else if (state == ST_HOLD && state_nx == ST_HOLD) begin
         bcnt  <= (bcnt == BLINK_LAST) ? '0 : bcnt + 1'b1;
         phase <= (bcnt == BLINK_LAST) ? !phase : phase;
      end else begin
         bcnt  <= '0;
         phase <= 1'b0;
      end
   end
   assign led_data = phase ? '0 : word;
`else
   assign led_data = word;
`endif
endmodule

// File: tb/tb_led_display_sequencer.sv
// tb_led_display_sequencer: directed per-cycle vectors pushed to a scoreboard, checked by a negedge monitor.
module tb_led_display_sequencer;
   logic       clk = 1'b0;
   logic       rst;
   logic       req0_valid, req1_valid, req0_ready, req1_ready, busy;
   logic [7:0] req0_data, req1_data, led_data;
   logic [1:0] grant;
   typedef struct packed {
      logic [7:0] led;
      logic [1:0] g;
      logic       b;
      logic [1:0] r;
      int         id;
   } exp_t;
   exp_t sb[$];
   exp_t e;
   int applied = 0;
   int miscompares = 0;
   int vec_id = 0;
   led_display_sequencer #(.HOLD_CYCLES(4), .STEP_CYCLES(3), .CNT_W(26)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .led_data   (led_data),
      .grant      (grant),
      .busy       (busy)
   );
   always #5 clk = ~clk;
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         e = sb.pop_front();
         applied++;
         if ({led_data, grant, busy, req1_ready, req0_ready} !== {e.led, e.g, e.b, e.r}) begin
            miscompares++;
            $display("FAIL vec%0d: got led=%h grant=%b busy=%b ready=%b, expected led=%h grant=%b busy=%b ready=%b",
                     e.id, led_data, grant, busy, {req1_ready, req0_ready}, e.led, e.g, e.b, e.r);
         end
      end
   end
   task automatic cyc(input int n, input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1,
                      input logic [7:0] el, input logic [1:0] eg, input logic eb, input logic [1:0] er);
      for (int i = 0; i < n; i++) begin
         req0_valid = v0;
         req0_data  = d0;
         req1_valid = v1;
         req1_data  = d1;
         vec_id++;
         sb.push_back('{led: el, g: eg, b: eb, r: er, id: vec_id});
         @(posedge clk);
         #1;
      end
   endtask
   initial begin
      rst = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      req0_data = '0;
      req1_data = '0;
      @(posedge clk);
      #1;
      // reset holds everything low even with requests pending
      cyc(2, 1, 8'hAA, 1, 8'hBB, 8'h00, 2'b00, 0, 2'b00);
      rst = 1'b1;
      cyc(1, 0, 0, 0, 0, 8'h00, 2'b00, 0, 2'b00);
      for (int k = 0; k < 8; k++) cyc(3, 0, 0, 0, 0, 8'h01 << k, 2'b00, 0, 2'b00);
      cyc(3, 0, 0, 0, 0, 8'h01, 2'b00, 0, 2'b00);
      // single request from port 0
      cyc(1, 1, 8'hA5, 0, 0, 8'h02, 2'b00, 0, 2'b01);
      cyc(4, 0, 0, 0, 0, 8'hA5, 2'b01, 1, 2'b00);
      cyc(1, 0, 0, 0, 0, 8'hA5, 2'b00, 0, 2'b00);
      cyc(3, 0, 0, 0, 0, 8'h02, 2'b00, 0, 2'b00);
      cyc(1, 0, 0, 0, 0, 8'h04, 2'b00, 0, 2'b00);
      // reset two clocks into a hold
      cyc(1, 1, 8'h3C, 0, 0, 8'h04, 2'b00, 0, 2'b01);
      cyc(2, 0, 0, 0, 0, 8'h3C, 2'b01, 1, 2'b00);
      rst = 1'b0;
      cyc(1, 0, 0, 0, 0, 8'h00, 2'b00, 0, 2'b00);
      cyc(1, 1, 8'h3C, 1, 8'h22, 8'h00, 2'b00, 0, 2'b00);
      rst = 1'b1;
      cyc(1, 0, 0, 0, 0, 8'h00, 2'b00, 0, 2'b00);
      // both ports held valid: strict alternation, port 0 first
      cyc(1, 1, 8'h11, 1, 8'h22, 8'h01, 2'b00, 0, 2'b01);
      cyc(4, 1, 8'h11, 1, 8'h22, 8'h11, 2'b01, 1, 2'b00);
      cyc(1, 1, 8'h11, 1, 8'h22, 8'h11, 2'b00, 0, 2'b10);
      cyc(4, 1, 8'h11, 1, 8'h22, 8'h22, 2'b10, 1, 2'b00);
      cyc(1, 1, 8'h11, 1, 8'h22, 8'h22, 2'b00, 0, 2'b01);
      cyc(4, 1, 8'h11, 1, 8'h22, 8'h11, 2'b01, 1, 2'b00);
      cyc(1, 0, 0, 0, 0, 8'h11, 2'b00, 0, 2'b00);
      // port 1 raises valid during a port 0 hold
      cyc(1, 1, 8'h55, 0, 0, 8'h01, 2'b00, 0, 2'b01);
      cyc(4, 0, 0, 1, 8'h22, 8'h55, 2'b01, 1, 2'b00);
      cyc(1, 0, 0, 1, 8'h22, 8'h55, 2'b00, 0, 2'b10);
      cyc(4, 0, 0, 0, 0, 8'h22, 2'b10, 1, 2'b00);
      cyc(1, 0, 0, 0, 0, 8'h22, 2'b00, 0, 2'b00);
      cyc(1, 0, 0, 0, 0, 8'h01, 2'b00, 0, 2'b00);
      @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d unchecked vectors, expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end
endmodule
